// File: rtl/c_register_block_pipelined.sv
// c_register_block_pipelined: C operand delay line, depth 0..MAX_DEPTH chosen by a scan-loaded config chain.
// Optional per-byte parity checking on the stages when C_REG_PARITY_EN is defined.
module c_register_block_pipelined #(
   parameter int WIDTH          = 48,
   parameter int MAX_DEPTH      = 2,
   parameter int FORCE_DEPTH_EN = 0,
   parameter int FORCED_DEPTH   = MAX_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     C,
   input  logic                 RSTC,
   input  logic                 CEC,
   output logic [WIDTH-1:0]     C_MUX,
   output logic [WIDTH-1:0]     C_reg,
   output logic                 C_valid,
   input  logic                 configuration_input,
   input  logic                 configuration_enable,
   output logic                 configuration_output
`ifdef C_REG_PARITY_EN
   ,
   output logic                 parity_err
`endif
);
   localparam int DW = $clog2(MAX_DEPTH + 1);

   logic              is_rstc_inverted;
   logic [DW-1:0]     creg_depth;
   logic [DW-1:0]     eff_depth;
   logic [DW-1:0]     fill;
   logic [DW+1:0]     chain_next;
   logic              rstc_x;
   logic [WIDTH-1:0]  stg [1:MAX_DEPTH];
   logic [WIDTH-1:0]  tap [0:MAX_DEPTH];

   // Chain shifts toward creg_depth[0]; the scan input lands in the inversion bit.
   assign chain_next = {configuration_input, is_rstc_inverted, creg_depth};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         {is_rstc_inverted, creg_depth} <= '0;
      else if (configuration_enable)
         {is_rstc_inverted, creg_depth} <= chain_next[DW+1:1];

   assign configuration_output = creg_depth[0];
   assign rstc_x               = RSTC ^ is_rstc_inverted;
   assign eff_depth = (FORCE_DEPTH_EN != 0) ? DW'(FORCED_DEPTH)
                    : (creg_depth > DW'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : creg_depth;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int k = 1; k <= MAX_DEPTH; k++) stg[k] <= '0;
      else if (rstc_x)
         for (int k = 1; k <= MAX_DEPTH; k++) stg[k] <= '0;
      else if (CEC) begin
         stg[1] <= C;
         for (int k = 2; k <= MAX_DEPTH; k++) stg[k] <= stg[k-1];
      end

   always_comb begin
      tap[0] = C;
      for (int k = 1; k <= MAX_DEPTH; k++) tap[k] = stg[k];
   end

   assign C_MUX = tap[eff_depth];
   assign C_reg = stg[MAX_DEPTH];

   // Any config shift invalidates the contents, but the data stages keep moving.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         fill <= '0;
      else if (rstc_x || configuration_enable)
         fill <= '0;
      else if (CEC && fill < eff_depth)
         fill <= fill + 1'b1;

   assign C_valid = rst_n & (fill >= eff_depth);

`ifdef C_REG_PARITY_EN
   localparam int NB = WIDTH / 8;

   logic [NB-1:0] pst  [1:MAX_DEPTH];
   logic [NB-1:0] ptap [0:MAX_DEPTH];

   function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] d);
      byte_par = '0;
      for (int b = 0; b < NB; b++) byte_par[b] = ^d[8*b +: 8];
   endfunction

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int k = 1; k <= MAX_DEPTH; k++) pst[k] <= '0;
      else if (rstc_x)
         for (int k = 1; k <= MAX_DEPTH; k++) pst[k] <= '0;
      else if (CEC) begin
         pst[1] <= byte_par(C);
         for (int k = 2; k <= MAX_DEPTH; k++) pst[k] <= pst[k-1];
      end

   always_comb begin
      ptap[0] = '0;
      for (int k = 1; k <= MAX_DEPTH; k++) ptap[k] = pst[k];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         parity_err <= 1'b0;
      else if (rstc_x)
         parity_err <= 1'b0;
      else if (eff_depth != '0 && byte_par(C_MUX) != ptap[eff_depth])
         parity_err <= 1'b1;
`endif
endmodule

// File: tb/tb_c_register_block_pipelined.sv
// tb_c_register_block_pipelined: vector table for the directed cases, queue scoreboard for a random stream.
module tb_c_register_block_pipelined;
   localparam int W = 48;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] C = '0;
   logic         RSTC = 1'b0;
   logic         CEC = 1'b0;
   logic [W-1:0] C_MUX;
   logic [W-1:0] C_reg;
   logic         C_valid;
   logic         cfg_in = 1'b0;
   logic         cfg_en = 1'b0;
   logic         configuration_output;
`ifdef C_REG_PARITY_EN
   logic         parity_err;
`endif

   c_register_block_pipelined #(.WIDTH(W), .MAX_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .C(C), .RSTC(RSTC), .CEC(CEC),
      .C_MUX(C_MUX), .C_reg(C_reg), .C_valid(C_valid),
      .configuration_input(cfg_in), .configuration_enable(cfg_en),
      .configuration_output(configuration_output)
`ifdef C_REG_PARITY_EN
      , .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           do_cfg;
      logic [2:0]   cfg;
      logic [2:0]   exp_so;
      logic         cec;
      logic         rstc;
      logic [W-1:0] c;
      logic [W-1:0] exp_mux;
      logic [W-1:0] exp_reg;
      logic         exp_valid;
   } vec_t;

   vec_t         v [11];
   int           passed = 0;
   int           total = 0;
   logic         cur_inv = 1'b0;
   logic [W-1:0] q [$];
   int           cnt;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // cfg is {inv, depth[1], depth[0]}; depth[0] goes in first.
   task automatic shift_cfg(input logic [2:0] bits, input logic [2:0] exp_so);
      for (int i = 0; i < 3; i++) begin
         RSTC = cur_inv;
         CEC = 1'b0;
         cfg_en = 1'b1;
         cfg_in = bits[i];
         @(posedge clk); #1;
         cur_inv = bits[i];
         check($sformatf("cfg_out shift %0d", i), {{(W-1){1'b0}}, configuration_output}, {{(W-1){1'b0}}, exp_so[i]});
      end
      cfg_en = 1'b0;
   endtask

   initial begin
      v[0]  = '{1'b1, 3'b110, 3'b000, 1'b1, 1'b1, 48'h1,    48'h0,    48'h0,   1'b0};
      v[1]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 48'h2,    48'h1,    48'h1,   1'b1};
      v[2]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 48'h3,    48'h2,    48'h2,   1'b1};
      v[3]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 48'hFFFF, 48'h0,    48'h0,   1'b0};
      v[4]  = '{1'b1, 3'b101, 3'b111, 1'b1, 1'b1, 48'hAA,   48'hAA,   48'h0,   1'b1};
      v[5]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 48'hBB,   48'hAA,   48'h0,   1'b1};
      v[6]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 48'hCC,   48'hCC,   48'hAA,  1'b1};
      v[7]  = '{1'b1, 3'b011, 3'b110, 1'b1, 1'b0, 48'h111,  48'hCC,   48'hCC,  1'b0};
      v[8]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 48'h222,  48'h111,  48'h111, 1'b1};
      v[9]  = '{1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 48'h5A5A, 48'h5A5A, 48'h111, 1'b1};
      v[10] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 48'h77,   48'h77,   48'h0,   1'b1};

      C = 48'h123;
      #12;
      check("reset C_MUX", C_MUX, 48'h123);
      check("reset C_reg", C_reg, '0);
      check("reset C_valid", {{(W-1){1'b0}}, C_valid}, '0);
      check("reset cfg_out", {{(W-1){1'b0}}, configuration_output}, '0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         if (v[i].do_cfg) shift_cfg(v[i].cfg, v[i].exp_so);
         CEC = v[i].cec;
         RSTC = v[i].rstc;
         C = v[i].c;
         @(posedge clk); #1;
         check($sformatf("vec%0d C_MUX", i), C_MUX, v[i].exp_mux);
         check($sformatf("vec%0d C_reg", i), C_reg, v[i].exp_reg);
         check($sformatf("vec%0d C_valid", i), {{(W-1){1'b0}}, C_valid}, {{(W-1){1'b0}}, v[i].exp_valid});
      end

      // Depth 0 is combinational: C_MUX follows C with no clock edge.
      C = 48'hABC;
      #1;
      check("depth0 comb C_MUX", C_MUX, 48'hABC);

      shift_cfg(3'b010, 3'b000);
      RSTC = 1'b1;
      CEC = 1'b0;
      @(posedge clk); #1;
      RSTC = 1'b0;
      q = '{48'h0, 48'h0};
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         logic [63:0] r;
         r = {$urandom, $urandom};
         C = r[W-1:0];
         CEC = ($urandom_range(0, 3) != 0);
         if (CEC) begin
            q.push_back(C);
            void'(q.pop_front());
            if (cnt < 2) cnt++;
         end
         @(posedge clk); #1;
         check($sformatf("sb%0d C_MUX", i), C_MUX, q[0]);
         check($sformatf("sb%0d C_reg", i), C_reg, q[0]);
         check($sformatf("sb%0d C_valid", i), {{(W-1){1'b0}}, C_valid}, (cnt >= 2) ? 48'h1 : 48'h0);
      end

      #3;
      rst_n = 1'b0;
      C = 48'h9999;
      #1;
      check("async C_MUX", C_MUX, 48'h9999);
      check("async C_reg", C_reg, '0);
      check("async C_valid", {{(W-1){1'b0}}, C_valid}, '0);
      check("async cfg_out", {{(W-1){1'b0}}, configuration_output}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      cur_inv = 1'b0;
      RSTC = 1'b0;
      CEC = 1'b1;
      C = 48'h42;
      @(posedge clk); #1;
      check("post-reset C_MUX", C_MUX, 48'h42);
      check("post-reset C_reg", C_reg, '0);
      check("post-reset C_valid", {{(W-1){1'b0}}, C_valid}, 48'h1);

`ifdef C_REG_PARITY_EN
      shift_cfg(3'b010, 3'b000);
      RSTC = 1'b0;
      CEC = 1'b1;
      C = 48'h0123_4567_89AB;
      @(posedge clk); #1;
      C = 48'hFEDC_BA98_7654;
      @(posedge clk); #1;
      CEC = 1'b0;
      check("parity clean", {{(W-1){1'b0}}, parity_err}, '0);
      @(negedge clk);
      dut.stg[2][9] = ~dut.stg[2][9];
      @(posedge clk); #1;
      check("parity flag", {{(W-1){1'b0}}, parity_err}, 48'h1);
      @(posedge clk); #1;
      check("parity sticky", {{(W-1){1'b0}}, parity_err}, 48'h1);
      RSTC = 1'b1;
      @(posedge clk); #1;
      RSTC = 1'b0;
      check("parity cleared", {{(W-1){1'b0}}, parity_err}, '0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
